// File: rtl/fp_align_pkg.sv
// Shared constants, field positions, FSM encodings and the unpacked
// operand bundle for the binary32 exponent-alignment stage.
package fp_align_pkg;

  localparam int MANT_W   = 24;
  localparam int EXP_W    = 8;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI   = 30;
  localparam int EXP_LO   = 23;
  localparam int FRAC_HI  = 22;

  localparam logic [EXP_W-1:0] MANT_W_E = EXP_W'(MANT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] mant;
  } fp_op_t;

endpackage

// File: rtl/fp_operand_unpack.sv
// Splits a binary32 word into sign, effective exponent and 24-bit mantissa.
// Ports: word (binary32 in), op (unpacked fp_op_t out). Purely combinational.
module fp_operand_unpack
  import fp_align_pkg::*;
(
  input  logic [31:0] word,
  output fp_op_t      op
);

  logic [EXP_W-1:0] exp_f;
  logic             hidden;

  assign exp_f  = word[EXP_HI:EXP_LO];
  assign hidden = |exp_f;

  // Denormals and zero share the effective exponent 1 of the smallest normal.
  assign op.sign = word[SIGN_BIT];
  assign op.expo = hidden ? exp_f : EXP_W'(1);
  assign op.mant = {hidden, word[FRAC_HI:0]};

endmodule

// File: rtl/fp_exp_align.sv
// Exponent-alignment stage: orders operands by magnitude and right-shifts the
// smaller mantissa one bit per cycle until exponents match.
// Ports: clk, rst (sync, high); in_valid/in_ready with a, b (binary32);
// out_valid/out_ready with mant_big, mant_small, exp_out, sign_big,
// sign_small, sticky. Macro FP_ALIGN_STICKY_EN builds the sticky logic.
module fp_exp_align
  import fp_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic [EXP_W-1:0]  exp_out,
  output logic              sign_big,
  output logic              sign_small,
  output logic              sticky
);

  fp_op_t           op_a;
  fp_op_t           op_b;
  fp_op_t           op_big;
  fp_op_t           op_small;
  logic             a_big;
  logic [EXP_W-1:0] diff;
  logic [EXP_W-1:0] cnt;
  state_t           state;
  state_t           state_n;

  fp_operand_unpack u_unpack_a (
    .word (a),
    .op   (op_a)
  );

  fp_operand_unpack u_unpack_b (
    .word (b),
    .op   (op_b)
  );

  // Ties go to A.
  assign a_big    = {op_a.expo, op_a.mant} >= {op_b.expo, op_b.mant};
  assign op_big   = a_big ? op_a : op_b;
  assign op_small = a_big ? op_b : op_a;
  assign diff     = op_big.expo - op_small.expo;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (diff == '0 || diff > MANT_W_E) state_n = DONE;
          else                               state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == EXP_W'(1)) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mant_big   <= '0;
      mant_small <= '0;
      exp_out    <= '0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mant_big   <= op_big.mant;
            exp_out    <= op_big.expo;
            sign_big   <= op_big.sign;
            sign_small <= op_small.sign;
            cnt        <= diff;
            // Beyond the adder width the whole mantissa falls off at once.
            mant_small <= (diff > MANT_W_E) ? '0 : op_small.mant;
          end
        end
        SHIFT: begin
          mant_small <= mant_small >> 1;
          cnt        <= cnt - EXP_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FP_ALIGN_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid)
            sticky_q <= (diff > MANT_W_E) ? |op_small.mant : 1'b0;
        end
        SHIFT: sticky_q <= sticky_q | mant_small[0];
        default: ;
      endcase
    end
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fp_exp_align.sv
// Self-checking bench for fp_exp_align: directed cases, backpressure,
// mid-shift reset and a random back-to-back run against a reference model.
module tb_fp_exp_align;

  typedef struct {
    logic [23:0] mb;
    logic [23:0] ms;
    logic [7:0]  e;
    logic        sb;
    logic        ss;
    logic        st;
    int          lat;
  } exp_t;

`ifdef FP_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] mant_big;
  logic [23:0] mant_small;
  logic [7:0]  exp_out;
  logic        sign_big;
  logic        sign_small;
  logic        sticky;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fp_exp_align dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_big   (mant_big),
    .mant_small (mant_small),
    .exp_out    (exp_out),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .sticky     (sticky)
  );

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [7:0]  ex, ey, eb, es;
    logic [23:0] mx, my, mb, ms;
    logic [31:0] mask;
    int          d;
    ex = (x[30:23] == 0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0]};
    my = {|y[30:23], y[22:0]};
    if ({ex, mx} >= {ey, my}) begin
      eb = ex; es = ey; mb = mx; ms = my; r.sb = x[31]; r.ss = y[31];
    end else begin
      eb = ey; es = ex; mb = my; ms = mx; r.sb = y[31]; r.ss = x[31];
    end
    d    = int'(eb) - int'(es);
    r.mb = mb;
    r.e  = eb;
    if (d > 24) begin
      r.ms  = '0;
      r.st  = STK & (|ms);
      r.lat = 0;
    end else begin
      mask  = (32'h1 << d) - 32'h1;
      r.ms  = ms >> d;
      r.st  = STK & (|({8'h0, ms} & mask));
      r.lat = d;
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [23:0] mb, input logic [23:0] ms,
                              input logic [7:0] e, input logic sb,
                              input logic ss, input logic st, input int lat);
    exp_t r;
    r.mb = mb; r.ms = ms; r.e = e; r.sb = sb; r.ss = ss; r.st = st;
    r.lat = lat;
    return r;
  endfunction

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input bit push, input exp_t ex);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    a = x; b = y; in_valid = 1'b1;
    if (push) q.push_back(ex);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid) begin
      if (lat >= 200) begin
        lat = -1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%0b in_ready=%0b required 0 0",
               out_valid, in_ready);
    end
    checks++;
    if ({mant_big, mant_small, exp_out, sign_big, sign_small, sticky} !== '0) begin
      errors++;
      $display("FAIL reset_data: mb=%h ms=%h e=%h required all 0",
               mant_big, mant_small, exp_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic run_directed(input string nm, input logic [31:0] x,
                              input logic [31:0] y, input exp_t ex);
    int lat;
    out_ready = 1'b1;
    send(x, y, 1'b1, ex);
    wait_out(lat);
    checks++;
    if (lat !== ex.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", nm, lat, ex.lat);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_return_idle: in_ready=%0b out_valid=%0b required 1 0",
               nm, in_ready, out_valid);
    end
  endtask

  task automatic test_diff1();
    run_directed("diff1", 32'h40000000, 32'h3F800000,
                 mk(24'h800000, 24'h400000, 8'h80, 0, 0, 0, 1));
  endtask

  task automatic test_equal_exp();
    run_directed("equal_exp", 32'h3F800000, 32'hBFC00000,
                 mk(24'hC00000, 24'h800000, 8'h7F, 1, 0, 0, 0));
  endtask

  task automatic test_diff24();
    run_directed("diff24", 32'h4B800000, 32'h3F800001,
                 mk(24'h800000, 24'h000000, 8'h97, 0, 0, STK, 24));
  endtask

  task automatic test_diff25();
    run_directed("diff25", 32'h4C000000, 32'h3F800000,
                 mk(24'h800000, 24'h000000, 8'h98, 0, 0, STK, 0));
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F000000, 1'b1,
         mk(24'hC00000, 24'h200000, 8'h80, 0, 0, 0, 2));
    wait_out(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL bp_latency: got %0d required 2", lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || mant_big !== 24'hC00000 ||
          mant_small !== 24'h200000 || exp_out !== 8'h80) begin
        errors++;
        $display("FAIL bp_hold_%0d: rdy=%0b vld=%0b mb=%h ms=%h e=%h required 0 1 c00000 200000 80",
                 i, in_ready, out_valid, mant_big, mant_small, exp_out);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1 0",
               in_ready, out_valid);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_no_extra: out_valid=%0b pending=%0d required 0 0",
               out_valid, q.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    exp_t dummy;
    dummy = mk(0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    send(32'h44800000, 32'h3F800000, 1'b0, dummy);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_busy: out_valid=%0b in_ready=%0b required 0 0",
               out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mant_big, mant_small, exp_out, sign_big, sign_small, sticky,
         out_valid, in_ready} !== '0) begin
      errors++;
      $display("FAIL mid_shift_reset: mb=%h ms=%h e=%h vld=%0b rdy=%0b required all 0",
               mant_big, mant_small, exp_out, out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift_release: in_ready=%0b required 1", in_ready);
    end
    run_directed("post_reset_diff1", 32'h40000000, 32'h3F800000,
                 mk(24'h800000, 24'h400000, 8'h80, 0, 0, 0, 1));
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    exp_t        ex;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      x = $urandom; y = $urandom;
      x[30:23] = 8'($urandom_range(110, 150));
      y[30:23] = 8'($urandom_range(110, 150));
      if ($urandom_range(0, 5) == 0) x[30:23] = 8'h00;
      if ($urandom_range(0, 5) == 0) y[30:23] = x[30:23];
      ex = model(x, y);
      send(x, y, 1'b1, ex);
      wait_out(lat);
      checks++;
      if (lat !== ex.lat) begin
        errors++;
        $display("FAIL b2b_latency_%0d: got %0d required %0d", i, lat, ex.lat);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    fork
      forever begin
        exp_t ex;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: mb=%h ms=%h required none",
                     mant_big, mant_small);
          end else begin
            ex = q.pop_front();
            if (mant_big !== ex.mb || mant_small !== ex.ms ||
                exp_out !== ex.e || sign_big !== ex.sb ||
                sign_small !== ex.ss || sticky !== ex.st) begin
              errors++;
              $display("FAIL result: mb=%h ms=%h e=%h sb=%0b ss=%0b st=%0b required mb=%h ms=%h e=%h sb=%0b ss=%0b st=%0b",
                       mant_big, mant_small, exp_out, sign_big, sign_small,
                       sticky, ex.mb, ex.ms, ex.e, ex.sb, ex.ss, ex.st);
            end
          end
        end
      end
    join_none

    test_reset();
    test_diff1();
    test_equal_exp();
    test_diff24();
    test_diff25();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();

    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
